// File: rtl/nvme_doorbell_arbiter.sv
// Round-robin arbiter sharing one NVMe doorbell-write engine across SQ-tail/CQ-head slots.
// Define DBL_TIMEOUT_EN to add the completion watchdog and sticky dbl_err flag.
module nvme_doorbell_arbiter #(
  parameter int unsigned NUM_Q          = 2,
  parameter logic [63:0] DBL_BASE       = 64'h0000_0000_8000_0000,
  parameter int unsigned DSTRD          = 0,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  localparam int unsigned NREQ          = 2 * NUM_Q
) (
  input  logic                 user_clk,
  input  logic                 user_reset_n,
  input  logic                 user_lnk_up,
  input  logic                 cfg_done,
  input  logic [NREQ-1:0]      dbl_req,
  input  logic [NREQ*16-1:0]   dbl_val,
  output logic [NREQ-1:0]      dbl_ack,
  output logic                 dbl_wr,
  output logic [63:0]          dbl_addr,
  output logic [31:0]          dbl_data,
  input  logic                 dbl_wr_done,
  output logic                 dbl_busy,
  output logic                 dbl_err,
  output logic [1:0]           arb_state
);

  localparam int unsigned GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  state_e                 state_q;
  logic [NREQ-1:0]        pend_q, pend_d;
  logic [NREQ-1:0][15:0]  val_q, val_d;
  logic [GW-1:0]          grant_q, last_q;
  logic [NREQ-1:0]        ack_q;
  logic                   wr_q;
  logic [63:0]            addr_q;
  logic [31:0]            data_q;

  logic [GW-1:0]          pick;
  logic                   pick_vld;
  logic                   grant_now;
  logic [63:0]            pick_addr;

  // Rotating priority: first pending slot after the last one served.
  always_comb begin
    int idx;
    pick_vld = 1'b0;
    pick     = '0;
    idx      = 0;
    for (int k = 1; k <= int'(NREQ); k++) begin
      idx = int'(last_q) + k;
      if (idx >= int'(NREQ)) idx = idx - int'(NREQ);
      if (!pick_vld && pend_q[idx]) begin
        pick_vld = 1'b1;
        pick     = GW'(idx);
      end
    end
  end

  assign grant_now = (state_q == ST_IDLE) && cfg_done && pick_vld;
  assign pick_addr = DBL_BASE + 64'h1000 + ({{(64-GW){1'b0}}, pick} << (2 + DSTRD));

  // A new request on the slot being granted wins over the grant's clear.
  always_comb begin
    pend_d = pend_q;
    val_d  = val_q;
    if (grant_now) pend_d[pick] = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (dbl_req[i]) begin
        pend_d[i] = 1'b1;
        val_d[i]  = dbl_val[16*i +: 16];
      end
    end
  end

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      pend_q <= '0;
      val_q  <= '0;
    end else if (!user_lnk_up) begin
      pend_q <= '0;
      val_q  <= '0;
    end else begin
      pend_q <= pend_d;
      val_q  <= val_d;
    end
  end

`ifdef DBL_TIMEOUT_EN
  logic        err_q;
  logic [31:0] cnt_q;
  logic [31:0] cnt_nxt;
  assign cnt_nxt = cnt_q + 32'd1;
`endif

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= GW'(NREQ - 1);
      ack_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
`ifdef DBL_TIMEOUT_EN
      err_q   <= 1'b0;
      cnt_q   <= '0;
`endif
    end else if (!user_lnk_up) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= GW'(NREQ - 1);
      ack_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
`ifdef DBL_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      ack_q <= dbl_req;
      wr_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant_now) begin
            grant_q <= pick;
            addr_q  <= pick_addr;
            data_q  <= {16'h0, val_q[pick]};
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          wr_q    <= 1'b1;
          state_q <= ST_WAIT;
`ifdef DBL_TIMEOUT_EN
          cnt_q   <= '0;
`endif
        end
        ST_WAIT: begin
          if (dbl_wr_done) begin
            last_q  <= grant_q;
            state_q <= ST_IDLE;
`ifdef DBL_TIMEOUT_EN
          end else if (cnt_nxt == TIMEOUT_CYCLES) begin
            // Writer never answered: drop this value and move on.
            err_q   <= 1'b1;
            last_q  <= grant_q;
            state_q <= ST_IDLE;
          end else begin
            cnt_q   <= cnt_nxt;
`endif
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign dbl_ack   = ack_q;
  assign dbl_wr    = wr_q;
  assign dbl_addr  = addr_q;
  assign dbl_data  = data_q;
  assign dbl_busy  = (state_q != ST_IDLE);
  assign arb_state = state_q;

`ifdef DBL_TIMEOUT_EN
  assign dbl_err = err_q;
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
  assign dbl_err    = 1'b0;
`endif

endmodule

// File: tb/tb_nvme_doorbell_arbiter.sv
// Self-checking bench for nvme_doorbell_arbiter: cycle model plus directed literal checks.
module tb_nvme_doorbell_arbiter;
  localparam int NR = 4;
  localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;
`ifdef DBL_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 65535;
`endif

  logic clk = 1'b0, rst_n = 1'b0, lnk = 1'b0, cfg = 1'b0, done = 1'b0;
  logic [NR-1:0]    req  = '0;
  logic [NR*16-1:0] dval = '0;
  logic [NR-1:0] ack, ack2;
  logic wr, wr2, busy, busy2, err, err2;
  logic [63:0] addr, addr2;
  logic [31:0] data, data2;
  logic [1:0]  st, st2;

  always #5 clk = ~clk;

  nvme_doorbell_arbiter #(.NUM_Q(2), .DBL_BASE(BASE), .DSTRD(0), .TIMEOUT_CYCLES(TMO)) u_dut (
    .user_clk(clk), .user_reset_n(rst_n), .user_lnk_up(lnk), .cfg_done(cfg),
    .dbl_req(req), .dbl_val(dval), .dbl_ack(ack), .dbl_wr(wr), .dbl_addr(addr),
    .dbl_data(data), .dbl_wr_done(done), .dbl_busy(busy), .dbl_err(err), .arb_state(st));

  nvme_doorbell_arbiter #(.NUM_Q(2), .DBL_BASE(BASE), .DSTRD(2), .TIMEOUT_CYCLES(TMO)) u_dut2 (
    .user_clk(clk), .user_reset_n(rst_n), .user_lnk_up(lnk), .cfg_done(cfg),
    .dbl_req(req), .dbl_val(dval), .dbl_ack(ack2), .dbl_wr(wr2), .dbl_addr(addr2),
    .dbl_data(data2), .dbl_wr_done(done), .dbl_busy(busy2), .dbl_err(err2), .arb_state(st2));

  int n_cmp = 0, n_err = 0, cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_pend[NR];
  logic [15:0] m_val[NR];
  int          m_last = NR - 1, m_stage = 0, m_g = 0, m_wait = 0;
  bit          m_clr = 1'b1;
  logic [NR-1:0] e_ack = '0;
  logic        e_wr = 1'b0, e_err = 1'b0;
  logic [63:0] e_addr = '0, e_addr2 = '0;
  logic [31:0] e_data = '0;

  function automatic logic [63:0] slot_addr(input int slot, input int stride_exp);
    return BASE + 64'd4096 + 64'(slot * (4 * (1 << stride_exp)));
  endfunction

  function automatic bit any_pend();
    for (int i = 0; i < NR; i++) if (m_pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void m_flush();
    for (int i = 0; i < NR; i++) begin m_pend[i] = 1'b0; m_val[i] = '0; end
    m_stage = 0; m_last = NR - 1; m_g = 0;
    e_ack = '0; e_wr = 1'b0; e_addr = '0; e_addr2 = '0; e_data = '0; m_clr = 1'b1;
  endfunction

  function automatic void model_step();
    bit found;
    if (!rst_n) begin
      m_flush(); e_err = 1'b0;
    end else if (!lnk) begin
      m_flush();
    end else begin
      e_ack = req;
      e_wr  = 1'b0;
      if (m_stage == 0) begin
        found = 1'b0;
        if (cfg) for (int k = 1; k <= NR; k++) begin
          int s;
          s = (m_last + k) % NR;
          if (!found && m_pend[s]) begin
            found = 1'b1; m_g = s;
            e_addr = slot_addr(s, 0); e_addr2 = slot_addr(s, 2);
            e_data = {16'h0, m_val[s]};
            m_pend[s] = 1'b0; m_stage = 1; m_clr = 1'b0;
          end
        end
      end else if (m_stage == 1) begin
        e_wr = 1'b1; m_stage = 2; m_wait = 0;
      end else begin
        m_wait++;
        if (done) begin
          m_last = m_g; m_stage = 0;
        end
`ifdef DBL_TIMEOUT_EN
        else if (m_wait == TMO) begin
          e_err = 1'b1; m_last = m_g; m_stage = 0;
        end
`endif
      end
      for (int i = 0; i < NR; i++) if (req[i]) begin
        m_pend[i] = 1'b1; m_val[i] = dval[16*i +: 16];
      end
    end
  endfunction

  // ---------------- write log ----------------
  typedef struct { logic [63:0] a; logic [63:0] a2; logic [31:0] d; int c; } wr_t;
  wr_t wlog[$];
  int  ack_cnt[NR];
  int  ack_cyc[NR];

  function automatic wr_t log_at(input int i);
    wr_t none;
    none = '{a: 64'hFFFF_FFFF_FFFF_FFFF, a2: 64'hFFFF_FFFF_FFFF_FFFF, d: 32'hFFFF_FFFF, c: -1};
    if (i < wlog.size()) return wlog[i];
    return none;
  endfunction

  // ---------------- compare process ----------------
  always @(posedge clk) begin
    cyc++;
    model_step();
    #1;
    chk("ack", ack, e_ack);
    chk("wr", wr, e_wr);
    chk("busy", busy, m_stage != 0);
    chk("state", st, m_stage);
    chk("err", err, e_err);
    chk("ack2", ack2, e_ack);
    chk("wr2", wr2, e_wr);
    chk("busy2", busy2, m_stage != 0);
    chk("state2", st2, m_stage);
    chk("err2", err2, e_err);
    if (m_stage != 0 || m_clr) begin
      chk("addr", addr, e_addr);
      chk("data", data, e_data);
      chk("addr2", addr2, e_addr2);
      chk("data2", data2, e_data);
    end
    if (wr) wlog.push_back('{a: addr, a2: addr2, d: data, c: cyc});
    for (int i = 0; i < NR; i++) if (ack[i]) begin ack_cnt[i]++; ack_cyc[i] = cyc; end
  end

  // ---------------- doorbell writer responder ----------------
  int resp_cnt = -1, fixed_lat = 2, resp_lat = 0, late_req = 0, late_ack = 0;
  bit hold_done = 1'b0, spur_en = 1'b0;

  always @(negedge clk) begin
    done = 1'b0;
    if (resp_cnt == 0) begin done = 1'b1; resp_cnt = -1; end
    else if (resp_cnt > 0) resp_cnt--;
    if (wr && !hold_done) begin
      resp_lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
      if (resp_lat == 0) done = 1'b1;
      else resp_cnt = resp_lat - 1;
    end
    if (late_req != late_ack) begin done = 1'b1; late_ack = late_req; end
    if (spur_en && !busy && $urandom_range(0, 39) == 0) done = 1'b1;
  end

  // ---------------- stimulus ----------------
  task automatic wait_idle(input string nm, input int budget);
    int n = 0;
    while (!(m_stage == 0 && !any_pend()) && n < budget) begin @(negedge clk); n++; end
    chk({nm, "_drain_timeout"}, n >= budget, 1'b0);
  endtask

  task automatic wait_state(input string nm, input logic [1:0] s, input int budget);
    int n = 0;
    while (st != s && n < budget) begin @(negedge clk); n++; end
    chk({nm, "_state_timeout"}, n >= budget, 1'b0);
  endtask

  task automatic lnk_pulse();
    lnk = 1'b0; @(negedge clk); lnk = 1'b1; @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int n0, c0, t0, tw, n;
    for (int i = 0; i < NR; i++) begin ack_cnt[i] = 0; ack_cyc[i] = 0; end
    repeat (3) @(negedge clk);
    chk("rst_state", st, 2'd0);
    chk("rst_addr", addr, 64'h0);
    chk("rst_ack", ack, 4'h0);
    rst_n = 1'b1; lnk = 1'b1;
    @(negedge clk);

    // Basic write on slot 0
    cfg = 1'b1; fixed_lat = 2;
    n0 = wlog.size();
    req[0] = 1'b1; dval[15:0] = 16'h0001; t0 = cyc;
    @(negedge clk); req = '0;
    wait_idle("basic", 40);
    chk("basic_nwr", wlog.size() - n0, 1);
    chk("basic_addr", log_at(n0).a, 64'h8000_1000);
    chk("basic_data", log_at(n0).d, 32'h1);
    chk("basic_wr_lat", log_at(n0).c - t0, 3);
    chk("basic_ack_lat", ack_cyc[0] - t0, 1);
    chk("basic_busy", busy, 1'b0);

    // CQ slot of qid 1, both strides
    n0 = wlog.size();
    req[3] = 1'b1; dval[63:48] = 16'd5;
    @(negedge clk); req = '0;
    wait_idle("cq", 40);
    chk("cq_addr", log_at(n0).a, 64'h8000_100C);
    chk("cq_addr_dstrd2", log_at(n0).a2, 64'h8000_1030);
    chk("cq_data", log_at(n0).d, 32'h5);

    // Coalescing three updates while arbitration is held off
    cfg = 1'b0; c0 = ack_cnt[1]; n0 = wlog.size();
    req[1] = 1'b1; dval[31:16] = 16'd2; @(negedge clk);
    dval[31:16] = 16'd3; @(negedge clk);
    dval[31:16] = 16'd7; @(negedge clk);
    req = '0;
    repeat (4) @(negedge clk);
    chk("coal_acks", ack_cnt[1] - c0, 3);
    chk("coal_held", wlog.size() - n0, 0);
    cfg = 1'b1;
    wait_idle("coal", 40);
    repeat (3) @(negedge clk);
    chk("coal_nwr", wlog.size() - n0, 1);
    chk("coal_data", log_at(n0).d, 32'h7);
    chk("coal_addr", log_at(n0).a, 64'h8000_1004);

    // Round-robin from last_grant = 3
    lnk_pulse(); cfg = 1'b0; n0 = wlog.size();
    req = 4'hF; dval = {16'd13, 16'd12, 16'd11, 16'd10};
    @(negedge clk); req = '0; cfg = 1'b1;
    wait_idle("rr1", 100);
    chk("rr1_nwr", wlog.size() - n0, 4);
    for (int k = 0; k < 4; k++) chk($sformatf("rr1_order%0d", k), log_at(n0 + k).d, 32'(10 + k));

    // Round-robin with slot 0 re-requested during its own write
    lnk_pulse(); cfg = 1'b0; n0 = wlog.size();
    req = 4'hF; dval = {16'd23, 16'd22, 16'd21, 16'd20};
    @(negedge clk); req = '0; cfg = 1'b1;
    n = 0;
    while (wlog.size() == n0 && n < 20) begin @(negedge clk); n++; end
    chk("rr2_first_timeout", n >= 20, 1'b0);
    req[0] = 1'b1; dval[15:0] = 16'd24;
    @(negedge clk); req = '0;
    wait_idle("rr2", 100);
    chk("rr2_nwr", wlog.size() - n0, 5);
    for (int k = 0; k < 5; k++) chk($sformatf("rr2_order%0d", k), log_at(n0 + k).d, 32'(20 + k));

    // Link down while waiting on the writer
    lnk_pulse(); cfg = 1'b0;
    req = 4'b0111; dval = {16'd0, 16'd32, 16'd31, 16'd30};
    @(negedge clk); req = '0; hold_done = 1'b1; cfg = 1'b1;
    wait_state("ld", 2'd2, 20);
    n0 = wlog.size();
    lnk = 1'b0; @(negedge clk);
    chk("ld_state", st, 2'd0);
    chk("ld_busy", busy, 1'b0);
    chk("ld_wr", wr, 1'b0);
    lnk = 1'b1; hold_done = 1'b0;
    repeat (5) @(negedge clk);
    late_req++;
    repeat (10) @(negedge clk);
    chk("ld_nowr", wlog.size() - n0, 0);
    chk("ld_idle", busy, 1'b0);

`ifdef DBL_TIMEOUT_EN
    // Watchdog: withhold completion, next pending slot still served
    lnk_pulse(); cfg = 1'b0;
    req = 4'b0110; dval = {16'd0, 16'd41, 16'd40, 16'd0};
    @(negedge clk); req = '0; hold_done = 1'b1; cfg = 1'b1;
    wait_state("tmo", 2'd2, 20);
    tw = cyc; n = 0;
    while (!err && n < 100) begin @(negedge clk); n++; end
    hold_done = 1'b0;
    chk("tmo_cycles", cyc - tw, 16);
    n0 = wlog.size();
    wait_idle("tmo", 40);
    chk("tmo_next_data", log_at(n0).d, 32'd41);
    chk("tmo_next_addr", log_at(n0).a, 64'h8000_1008);
    chk("tmo_sticky", err, 1'b1);
`else
    tw = 0;
`endif

    // Randomized traffic
    fixed_lat = -1; spur_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      lnk = ($urandom_range(0, 299) != 0);
      cfg = ($urandom_range(0, 15) != 0);
      for (int i = 0; i < NR; i++) req[i] = ($urandom_range(0, 4) == 0);
      dval = {$urandom, $urandom};
    end
    @(negedge clk);
    req = '0; lnk = 1'b1; cfg = 1'b1; spur_en = 1'b0;
    wait_idle("final", 200);
    repeat (6) @(negedge clk);

    // Asynchronous reset clears outputs immediately
    rst_n = 1'b0; #1;
    chk("areset_state", st, 2'd0);
    chk("areset_err", err, 1'b0);
    chk("areset_ack", ack, 4'h0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/nvme_doorbell_arbiter.md
Name: nvme_doorbell_arbiter

Overview:
- Shares the single doorbell-write engine between multiple queue requesters: NUM_Q queue pairs, each with an SQ-tail slot and a CQ-head slot.
- Latches tail/head updates per slot and coalesces repeated updates to a slot (latest value wins).
- Arbitrates round-robin, computes the NVMe doorbell address, and issues one write at a time with a done handshake.
- Sits between the controller FSM / command-issue logic and the PCIe RQ doorbell writer.

Parameters:
- NUM_Q, 2, number of queue pairs (admin = qid 0); NREQ = 2*NUM_Q slots, slot i -> qid = i>>1, is_cq = i[0]
- DBL_BASE, 64'h0000_0000_8000_0000, BAR0 base of the controller register space
- DSTRD, 0, CAP.DSTRD doorbell stride; slot stride = 4 << DSTRD bytes
- TIMEOUT_CYCLES, 65535, completion watchdog limit (only with DBL_TIMEOUT_EN)

Ports:
- user_clk  in  1  clock
- user_reset_n  in  1  async active-low reset
- user_lnk_up  in  1  link up; low = synchronous flush
- cfg_done  in  1  arbitration enable; pending slots are held until high
- dbl_req  in  NREQ  per-slot update strobe, 1 cycle per update
- dbl_val  in  NREQ*16  per-slot new tail/head value; slot i = [16*i+15:16*i]
- dbl_ack  out  NREQ  1-cycle pulse, cycle after the update is latched
- dbl_wr  out  1  1-cycle write pulse to the doorbell writer
- dbl_addr  out  64  doorbell address, stable from dbl_wr until done
- dbl_data  out  32  {16'h0, value}, stable from dbl_wr until done
- dbl_wr_done  in  1  writer completion pulse
- dbl_busy  out  1  high in any state other than ST_IDLE
- dbl_err  out  1  sticky timeout flag
- arb_state  out  2  FSM state, for debug

Behaviour:
- Reset (async, user_reset_n=0):
  - all outputs 0; pending[] = 0, val[] = 0, grant = 0, last_grant = NREQ-1, state ST_IDLE.
- user_lnk_up=0 (synchronous):
  - same clearing as reset, except dbl_err is held.
  - Takes effect mid-transaction too: any outstanding dbl_wr_done is ignored.
- Latch, each cycle, per slot i:
  - if dbl_req[i]: pending[i] <= 1, val[i] <= slice i, dbl_ack[i] <= 1 on the next cycle.
  - A request on a slot that is already pending overwrites val (coalescing); exactly one write is issued.
- FSM, states ST_IDLE=0, ST_ISSUE=1, ST_WAIT=2:
  - ST_IDLE:
    - if cfg_done && |pending: grant g = first set slot searching from last_grant+1 upward, wrapping modulo NREQ.
    - Latch dbl_addr = DBL_BASE + 64'h1000 + (g << (2+DSTRD)) and dbl_data = {16'h0, val[g]}.
    - Clear pending[g] -> ST_ISSUE.
  - ST_ISSUE: dbl_wr <= 1 for exactly one cycle -> ST_WAIT.
  - ST_WAIT: dbl_wr = 0; on dbl_wr_done: last_grant <= g -> ST_IDLE.
    - dbl_wr_done in any other state is ignored.
- Simultaneous events:
  - dbl_req[g] in the same cycle the grant clears pending[g]: the set wins, pending[g] stays 1 and val takes the new value.
  - The write in flight carries the old value; the new value is issued later.
  - Updates to a slot whose write is in flight set pending; they never alter the in-flight dbl_addr/dbl_data.
- Latency:
  - dbl_req at cycle 0 with the arbiter idle: pending at 1, ST_ISSUE at 2, dbl_wr high at 3.
  - Minimum back-to-back spacing is 3 cycles plus writer latency.
- Fairness: a continuously requesting slot cannot starve others; every pending slot is served within NREQ grants.
- Address arithmetic is 64-bit; g is zero-extended before the shift.

Optional Feature:
- DBL_TIMEOUT_EN defined:
  - a 32-bit counter clears on entry to ST_WAIT and counts every ST_WAIT cycle.
  - At count == TIMEOUT_CYCLES without dbl_wr_done: dbl_err <= 1 (sticky until reset), last_grant <= g, -> ST_IDLE.
  - The granted value is dropped.
- Not defined: no counter; ST_WAIT waits indefinitely; dbl_err tied 0.

Test Plan:
- Basic write, DSTRD=0: cfg_done=1, single dbl_req[0] with val=16'h0001 -> dbl_ack[0] next cycle; dbl_wr 3 cycles after req; dbl_addr=64'h8000_1000, dbl_data=32'h1; done -> busy drops.
- CQ slot address: req slot 3 (qid1 CQ) val=5 -> dbl_addr=64'h8000_100C. Rerun with DSTRD=2 -> 64'h8000_1030.
- Coalescing: cfg_done=0, slot 1 reqs val=2,3,7 -> three acks; raise cfg_done -> exactly one dbl_wr, data=32'h7.
- Round-robin: all 4 slots pending with last_grant=3, writer acks in 2 cycles -> grant order 0,1,2,3. Re-request slot 0 during its write -> order 0,1,2,3,0.
- Link-down mid-write: drop user_lnk_up in ST_WAIT with 2 slots pending -> next cycle state 0, pending 0, dbl_wr 0; a late dbl_wr_done causes no action.
- DBL_TIMEOUT_EN with TIMEOUT_CYCLES=16: withhold done -> dbl_err=1 after 16 ST_WAIT cycles, return to idle, next pending slot served normally.
